// File: rtl/fetch_align_pkg.sv
// Shared types for the instruction fetch aligner: buffer entry, FSM state, RVC length decode.
// No logic of its own; imported by fetch_align.
package fetch_align_pkg;

    localparam int WORD_AW = 30;

    // Tag keeps the whole word address so the struct does not depend on ENTRIES;
    // the index bits it carries always agree with the slot and never cause a false miss.
    typedef struct packed {
        logic               valid;
        logic [WORD_AW-1:0] tag;
        logic [31:0]        data;
    } fetch_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    function automatic logic is_compressed(input logic [15:0] half);
        return half[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_align.sv
// Fetch front end: direct-mapped word buffer returning one 16/32-bit RV32IC instruction per request.
// Latency: hits answer combinationally in the request cycle; each missing word costs one memory access.
// Backpressure: fetch_ready held low until every needed word is buffered; one memory access outstanding.
module fetch_align
    import fetch_align_pkg::*;
#(
    parameter int ENTRIES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_flush,
    output logic [31:0] fetch_rdata,
    output logic        fetch_ready,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int IW = $clog2(ENTRIES);

    fetch_entry_t entry_q [ENTRIES];
    fetch_state_t state_q, state_d;
    logic         discard_q;

    logic [WORD_AW-1:0] w0, w1, miss_word;
    logic [IW-1:0]      idx0, idx1, fill_idx;
    fetch_entry_t       e0, e1, fill_entry;
    logic               hit0, hit1, need_w1, all_hit, comp, issue, fill;
    logic [15:0]        half0;
    logic               addr_bit0_unused;

    assign addr_bit0_unused = fetch_addr[0];
    assign mem_instr        = 1'b1;

    // Lookup: the length decode only needs the first halfword, so W+1 is required
    // exactly when the request starts in the upper half and is not compressed.
    always_comb begin
        w0      = fetch_addr[31:2];
        w1      = w0 + 30'd1;
        idx0    = w0[IW-1:0];
        idx1    = w1[IW-1:0];
        e0      = entry_q[idx0];
        e1      = entry_q[idx1];
        hit0    = e0.valid && (e0.tag == w0);
        hit1    = e1.valid && (e1.tag == w1);
        half0   = fetch_addr[1] ? e0.data[31:16] : e0.data[15:0];
        comp    = is_compressed(half0);
        need_w1 = fetch_addr[1] && !comp;
        all_hit = hit0 && (!need_w1 || hit1);
        miss_word = hit0 ? w1 : w0;

        fetch_ready = fetch_valid && !fetch_flush && all_hit;
        fetch_rdata = 32'h0;
        if (fetch_ready) begin
            if (comp)
                fetch_rdata = {16'h0, half0};
            else if (!fetch_addr[1])
                fetch_rdata = e0.data;
            else
                fetch_rdata = {e1.data[15:0], e0.data[31:16]};
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_valid && !fetch_flush && !all_hit) begin
                    issue   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fill is keyed by the latched request address, never by the live fetch_addr.
    always_comb begin
        fill             = (state_q == WAIT) && mem_ready && !discard_q;
        fill_idx         = mem_addr[IW+1:2];
        fill_entry.valid = 1'b1;
        fill_entry.tag   = mem_addr[31:2];
        fill_entry.data  = mem_rdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= 32'h0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_valid <= issue;
            if (issue)
                mem_addr <= {miss_word, 2'b00};
            if (state_q == WAIT && !mem_ready)
                discard_q <= discard_q || fetch_flush;
            else
                discard_q <= 1'b0;
        end
    end

    // Flush outranks a same-cycle fill, so data returning with a flush is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++)
                entry_q[i] <= '0;
        end else if (fetch_flush) begin
            for (int i = 0; i < ENTRIES; i++)
                entry_q[i].valid <= 1'b0;
        end else if (fill) begin
            entry_q[fill_idx] <= fill_entry;
        end
    end

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align: memory image + instruction-level reference, per-cycle compare.
module tb_fetch_align;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        fetch_flush;
    logic [31:0] fetch_rdata;
    logic        fetch_ready;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    fetch_align #(.ENTRIES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .fetch_flush (fetch_flush),
        .fetch_rdata (fetch_rdata),
        .fetch_ready (fetch_ready),
        .mem_valid   (mem_valid),
        .mem_instr   (mem_instr),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    always #5 clock = ~clock;

    // Memory image, word addressed
    logic [31:0] mem [logic [29:0]];

    function automatic logic [31:0] rd(input logic [29:0] w);
        return mem.exists(w) ? mem[w] : 32'h0;
    endfunction

    // Instruction at a halfword address, straight from the memory image
    function automatic logic [31:0] model_instr(input logic [31:0] a);
        logic [29:0] w;
        logic [31:0] lo, hi;
        logic [15:0] first;
        w  = a[31:2];
        lo = rd(w);
        hi = rd(w + 30'd1);
        first = a[1] ? lo[31:16] : lo[15:0];
        if (first[1:0] != 2'b11) return {16'h0, first};
        if (!a[1]) return lo;
        return {hi[15:0], lo[31:16]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory responder: answers each pulse after lat cycles, logs every pulse
    int          lat = 2;
    bit          resp_en = 1'b1;
    bit          force_rdy = 1'b0;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    int          acc_cnt = 0;
    logic [31:0] acc_q [$];

    always @(negedge clock) begin
        mem_ready = 1'b0;
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (force_rdy) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hDEADBEEF;
                force_rdy = 1'b0;
            end
            if (pend) begin
                checks++;
                if (mem_addr !== pend_addr) begin
                    errors++;
                    $display("FAIL mem_addr_hold: got %h expected %h", mem_addr, pend_addr);
                end
                cnt--;
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd(pend_addr[31:2]);
                    pend = 1'b0;
                end
            end
            if (mem_valid) begin
                acc_cnt++;
                acc_q.push_back(mem_addr);
                if (resp_en) begin
                    pend = 1'b1;
                    pend_addr = mem_addr;
                    cnt = lat;
                end
            end
        end
    end

    // Per-cycle compare against the instruction-level reference
    always @(negedge clock) begin
        checks++;
        if (fetch_ready) begin
            if (!reset || !fetch_valid || fetch_flush || fetch_rdata !== model_instr(fetch_addr)) begin
                errors++;
                $display("FAIL cmp_rdata: addr %h got %h expected %h (valid %b flush %b)",
                         fetch_addr, fetch_rdata, model_instr(fetch_addr), fetch_valid, fetch_flush);
            end
        end else if (fetch_rdata !== 32'h0) begin
            errors++;
            $display("FAIL cmp_idle_rdata: got %h expected 00000000", fetch_rdata);
        end
    end

    function automatic logic [31:0] acc_at(input int i);
        return (acc_q.size() > i) ? acc_q[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic pulse_flush();
        @(posedge clock); #1;
        fetch_flush = 1'b1;
        @(posedge clock); #1;
        fetch_flush = 1'b0;
    endtask

    // Holds a request until fetch_ready; optional one-cycle flush at cycle flush_at
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp, input int exp_acc,
                            input int flush_at, input string nm);
        int  acc0;
        int  ncyc;
        bit  got;
        logic [31:0] rdat;
        acc0 = acc_cnt;
        got  = 1'b0;
        ncyc = 0;
        rdat = 32'h0;
        @(posedge clock); #1;
        fetch_valid = 1'b1;
        fetch_addr  = a;
        for (int c = 0; c < 60; c++) begin
            fetch_flush = (c == flush_at);
            @(negedge clock);
            if (fetch_ready) begin
                got  = 1'b1;
                ncyc = c;
                rdat = fetch_rdata;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        fetch_valid = 1'b0;
        fetch_flush = 1'b0;
        chk({nm, "_ready"}, 32'(got), 32'd1);
        chk({nm, "_rdata"}, rdat, exp);
        chk({nm, "_accesses"}, 32'(acc_cnt - acc0), 32'(exp_acc));
        if (exp_acc == 0)
            chk({nm, "_latency"}, 32'(ncyc), 32'd0);
    endtask

    initial begin
        int  n;
        bit  seen;
        reset       = 1'b0;
        fetch_valid = 1'b0;
        fetch_addr  = 32'h0;
        fetch_flush = 1'b0;
        mem_rdata   = 32'h0;
        mem_ready   = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("rst_fetch_rdata", fetch_rdata, 32'h0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        reset = 1'b1;
        @(negedge clock);
        chk("mem_instr", 32'(mem_instr), 32'd1);

        // Pin the reference model with hand-computed values
        mem[30'h0] = 32'h41014081;
        mem[30'h1] = 32'h0E870000;
        mem[30'h2] = 32'h000001C3;
        chk("model_lo", model_instr(32'h0), 32'h00004081);
        chk("model_hi", model_instr(32'h2), 32'h00004101);
        chk("model_span", model_instr(32'h6), 32'h01C30E87);

        // Compressed halves of word 0
        n = acc_q.size();
        do_fetch(32'h0, 32'h00004081, 1, -1, "c_lo_miss");
        chk("c_lo_addr", acc_at(n), 32'h0);
        do_fetch(32'h2, 32'h00004101, 0, -1, "c_hi_hit");

        // New image, aliasing on index 0
        mem[30'h0] = 32'h02B74F81;
        mem[30'h2] = 32'h000302B7;
        pulse_flush();
        do_fetch(32'h0, 32'h00004F81, 1, -1, "c_4f81");
        do_fetch(32'h8, 32'h000302B7, 1, -1, "w32_8");
        do_fetch(32'h0, 32'h00004F81, 1, -1, "alias");

        // Upper-half compressed needs only its own word
        mem[30'h1] = 32'h0E850000;
        pulse_flush();
        do_fetch(32'h6, 32'h00000E85, 1, -1, "c_upper");

        // Spanning 32-bit instruction: two sequential accesses, then a hit
        mem[30'h1] = 32'h0E870000;
        mem[30'h2] = 32'h000001C3;
        pulse_flush();
        n = acc_q.size();
        do_fetch(32'h6, 32'h01C30E87, 2, -1, "span");
        chk("span_addr0", acc_at(n), 32'h4);
        chk("span_addr1", acc_at(n + 1), 32'h8);
        do_fetch(32'h6, 32'h01C30E87, 0, -1, "span_hit");

        // Flush while waiting, and flush coincident with mem_ready
        lat = 4;
        pulse_flush();
        do_fetch(32'h0, 32'h00004F81, 2, 3, "flush_wait");
        pulse_flush();
        do_fetch(32'h0, 32'h00004F81, 2, 5, "flush_rdy");
        lat = 2;

        // Wrap from the top word to word 0
        mem[30'h3FFFFFFF] = 32'hABC70000;
        pulse_flush();
        n = acc_q.size();
        do_fetch(32'hFFFFFFFE, 32'h4F81ABC7, 2, -1, "wrap");
        chk("wrap_addr0", acc_at(n), 32'hFFFFFFFC);
        chk("wrap_addr1", acc_at(n + 1), 32'h0);

        // Reset in the middle of an access; late mem_ready must not fill
        pulse_flush();
        resp_en = 1'b0;
        @(posedge clock); #1;
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (mem_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_mid_pulse_seen", 32'(seen), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mid_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("rst_mid_mem_addr", mem_addr, 32'h0);
        fetch_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        force_rdy = 1'b1;
        repeat (3) @(posedge clock);
        resp_en = 1'b1;
        do_fetch(32'h0, 32'h00004F81, 1, -1, "after_late_rdy");

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
